// File: rtl/run_controller_pkg.sv
// Shared definitions for the run controller: FSM state encoding and the
// default job geometry (operand block, result window) that the program
// assembler also relies on.
package run_controller_pkg;

    typedef enum logic [2:0] {
        RC_IDLE,
        RC_INIT,
        RC_LOAD,
        RC_RUN,
        RC_DRAIN
    } rc_state_t;

    localparam int RC_LOAD_LEN = 64;
    localparam int RC_RES_BASE = 64;
    localparam int RC_RES_LEN  = 32;

    function automatic int rc_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/run_controller.sv
// Host-side job sequencer for the processor core: holds the core in init,
// streams an operand block into data memory, lets the core run until ack
// (or a timeout), then streams the result window back to the host.
// Optional feature: define RUN_CYCLE_COUNT_EN to add the run_cycles output.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int LOAD_LEN = RC_LOAD_LEN,
    parameter int RES_BASE = RC_RES_BASE,
    parameter int RES_LEN  = RC_RES_LEN,
    parameter int INIT_CYC = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         core_init,
    output logic         core_req,
    input  logic         core_ack,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
`ifdef RUN_CYCLE_COUNT_EN
    ,
    output logic [31:0]  run_cycles
`endif
);

    // One counter serves every phase: INIT hold, LOAD address, RUN timeout, DRAIN offset.
    localparam int CW = $clog2(rc_max3(LOAD_LEN, RES_LEN, TIMEOUT) + 1);

    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYC - 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_LEN - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RES_LAST  = CW'(RES_LEN - 1);

    if (LOAD_LEN < 1 || RES_LEN < 1) begin : g_len_check
        $error("run_controller: LOAD_LEN and RES_LEN must both be non-zero");
    end

    if (INIT_CYC < 1 || INIT_CYC > (1 << CW) || TIMEOUT < 1) begin : g_cyc_check
        $error("run_controller: INIT_CYC and TIMEOUT must be in range");
    end

    rc_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          kick_q, kick_d;   // one-cycle core_init pulse after a timeout

    // Next-state and output decode; outputs are purely a function of state and handshakes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        kick_d    = 1'b0;
        busy      = (state_q != RC_IDLE);
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        core_init = kick_q;
        core_req  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            RC_IDLE: begin
                if (start) begin
                    state_d = RC_INIT;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            RC_INIT: begin
                core_init = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    state_d = RC_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RC_LOAD: begin
                in_ready = 1'b1;
                mem_addr = A'(cnt_q);
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                    if (cnt_q == LOAD_LAST) begin
                        state_d = RC_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RC_RUN: begin
                core_req = 1'b1;
                // An ack on the last allowed cycle still counts as success.
                if (core_ack) begin
                    state_d = RC_DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = RC_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    kick_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RC_DRAIN: begin
                // Address only moves on a beat, so out_data holds while stalled.
                mem_addr  = A'(RES_BASE) + A'(cnt_q);
                out_valid = 1'b1;
                out_data  = mem_rdata;
                if (out_ready) begin
                    if (cnt_q == RES_LAST) begin
                        state_d = RC_IDLE;
                        cnt_d   = '0;
                        done    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = RC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any job silently.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= RC_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            kick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            kick_q  <= kick_d;
        end
    end

    assign err = err_q;

`ifdef RUN_CYCLE_COUNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    // RUN-phase cycle count of the latest job: restarts on an accepted start, saturates.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_q == RC_IDLE && start) begin
            run_cycles_d = '0;
        end else if (state_q == RC_RUN && run_cycles_q != '1) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    // Run-cycle counter register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: drives randomized jobs (operand beats, core ack
// delay, host back-pressure) and checks memory writes and result bytes via
// queues popped by an independent monitor.
module tb_run_controller;

    localparam int W        = 8;
    localparam int A        = 8;
    localparam int LOAD_LEN = 64;
    localparam int RES_BASE = 64;
    localparam int RES_LEN  = 32;
    localparam int INIT_CYC = 2;
    localparam int TIMEOUT  = 128;
    localparam int RI       = $clog2(RES_LEN);

    typedef struct packed {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic         Clk       = 1'b0;
    logic         Reset     = 1'b0;
    logic         start     = 1'b0;
    logic         busy, done, err;
    logic [W-1:0] in_data   = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         core_init, core_req;
    logic         core_ack  = 1'b0;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata, mem_rdata;
`ifdef RUN_CYCLE_COUNT_EN
    logic [31:0]  run_cycles;
`endif

    run_controller #(
        .W(W), .A(A), .LOAD_LEN(LOAD_LEN), .RES_BASE(RES_BASE),
        .RES_LEN(RES_LEN), .INIT_CYC(INIT_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .busy(busy), .done(done), .err(err),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_init(core_init), .core_req(core_req), .core_ack(core_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef RUN_CYCLE_COUNT_EN
        , .run_cycles(run_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    // Data memory model: operand area written by the DUT, result window filled by the "core".
    logic [W-1:0] load_mem [0:(1<<A)-1];
    logic [W-1:0] res_mem  [RES_LEN];
    logic [A-1:0] res_off;
    assign res_off   = mem_addr - A'(RES_BASE);
    assign mem_rdata = (int'(res_off) < RES_LEN) ? res_mem[res_off[RI-1:0]] : load_mem[mem_addr];
    always @(posedge Clk) if (mem_we) load_mem[mem_addr] <= mem_wdata;

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    wr_t          exp_wr [$];
    logic [W-1:0] exp_out[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes memory or hands over a result byte.
    wr_t          mon_e;
    logic [W-1:0] mon_b;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    always @(negedge Clk) begin
        if (!Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
                end
            end
            if (out_valid && prev_stall) check("out_hold_while_stalled", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_out_byte: got %0h, none expected", out_data);
                end else begin
                    mon_b = exp_out.pop_front();
                    check("out_byte", 32'(out_data), 32'(mon_b));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // One job: ack_delay=0 means the core never acks (timeout).
    // vmode 0: in_valid held, data=addr, results 0xA0+i; 1: random gaps and data.
    // rmode 0: out_ready held; 1: toggles starting low; 2: random.
    task automatic run_job(input int ack_delay, input int vmode, input int rmode, input bit pulse_start);
        logic [W-1:0] bytes [LOAD_LEN];
        int k, n_init, n_load, cyc, n, m, d0;
        bit first, got_done;
        for (int i = 0; i < LOAD_LEN; i++) begin
            bytes[i] = (vmode == 0) ? W'(i) : W'($urandom);
            exp_wr.push_back({A'(i), bytes[i]});
        end
        for (int i = 0; i < RES_LEN; i++) begin
            res_mem[i] = (vmode == 0) ? W'(8'hA0 + i) : W'($urandom);
            if (ack_delay != 0) exp_out.push_back(res_mem[i]);
        end
        d0 = done_cnt;
        out_ready = (rmode == 0);
        @(posedge Clk); #1; start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        in_data  = bytes[0];
        k = 0; n_init = 0; n_load = 0; cyc = 0; first = 1'b1;
        while (k < LOAD_LEN && cyc < 1000) begin
            @(negedge Clk);
            if (first) begin
                check("err_clear_on_start", 32'(err), 0);
                check("busy_in_init", 32'(busy), 1);
                first = 1'b0;
            end
            if (core_init) n_init++;
            if (in_ready) n_load++;
            if (in_ready && in_valid) k++;
            cyc++;
            @(posedge Clk); #1;
            if (k < LOAD_LEN) begin
                in_valid = (vmode == 0) || ($urandom_range(0, 3) != 0);
                in_data  = bytes[k];
            end else begin
                in_valid = 1'b0;
            end
        end
        check("load_beats", k, LOAD_LEN);
        if (k < LOAD_LEN) return;
        check("init_cycles", n_init, INIT_CYC);
        if (vmode == 0) check("load_cycles", n_load, LOAD_LEN);

        n = 0; cyc = 0;
        while (cyc < TIMEOUT + 50) begin
            core_ack = (ack_delay != 0) && (n + 1 == ack_delay);
            start    = pulse_start && (n == 4);
            @(negedge Clk);
            if (!core_req) break;
            n++; cyc++;
            @(posedge Clk); #1;
        end
        core_ack = 1'b0; start = 1'b0;
        check("run_cycles_seen", n, (ack_delay != 0) ? ack_delay : TIMEOUT);

        if (ack_delay == 0) begin
            check("to_err", 32'(err), 1);
            check("to_core_init_pulse", 32'(core_init), 1);
            check("to_busy", 32'(busy), 0);
            @(posedge Clk); #1; @(negedge Clk);
            check("to_core_init_end", 32'(core_init), 0);
            check("to_err_sticky", 32'(err), 1);
            check("to_no_done", done_cnt - d0, 0);
`ifdef RUN_CYCLE_COUNT_EN
            check("run_cycles_timeout", run_cycles, TIMEOUT);
`endif
        end else begin
            m = 0; got_done = 1'b0; cyc = 0;
            while (!got_done && cyc < 400) begin
                if (out_valid) m++;
                if (done) got_done = 1'b1;
                cyc++;
                @(posedge Clk); #1;
                case (rmode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ~out_ready;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (!got_done) @(negedge Clk);
            end
            check("drain_done_seen", 32'(got_done), 1);
            if (rmode == 0) check("drain_cycles", m, RES_LEN);
            if (rmode == 1) check("drain_cycles_toggle", m, 2 * RES_LEN);
            @(negedge Clk);
            check("busy_after_done", 32'(busy), 0);
            check("done_once", done_cnt - d0, 1);
            check("out_queue_empty", exp_out.size(), 0);
`ifdef RUN_CYCLE_COUNT_EN
            check("run_cycles_after_done", run_cycles, ack_delay);
`endif
        end
        check("wr_queue_empty", exp_wr.size(), 0);
        exp_out.delete();
        exp_wr.delete();
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_load();
        int d0;
        for (int i = 0; i < LOAD_LEN; i++) exp_wr.push_back({A'(i), 8'h55});
        d0 = done_cnt;
        @(posedge Clk); #1; start = 1'b1;
        @(posedge Clk); #1; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        repeat (INIT_CYC + 20) begin @(posedge Clk); #1; end
        Reset = 1'b0;
        @(posedge Clk); #1; @(negedge Clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_core_init", 32'(core_init), 0);
        check("rst_core_req", 32'(core_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        @(posedge Clk); #1; @(posedge Clk); #1;
        Reset = 1'b1; in_valid = 1'b0;
        exp_wr.delete();
        @(negedge Clk);
        check("rst_still_idle", 32'(busy), 0);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_err", 32'(err), 0);
    endtask

    initial begin
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1; @(negedge Clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_core_init", 32'(core_init), 0);
        check("reset_core_req", 32'(core_req), 0);
        check("reset_mem_we", 32'(mem_we), 0);
        @(posedge Clk); #1; Reset = 1'b1;

        run_job(100, 0, 0, 1'b1);
        run_job(int'($urandom_range(5, 60)), 1, 1, 1'b0);
        run_job(0, 1, 0, 1'b0);
        run_job(int'($urandom_range(1, 120)), 1, 2, 1'b0);
        reset_mid_load();
        run_job(1, 1, 2, 1'b0);
        for (int j = 0; j < 3; j++) run_job(int'($urandom_range(1, TIMEOUT - 1)), 1, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched so far", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
